// File: rtl/sram_write_arbiter_pkg.sv
// Shared types and defaults for the SRAM write-slot arbiter.
// The phase names mirror the SRAM controller's four-stage round.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        PH_W1  = 2'd0,
        PH_VGA = 2'd1,
        PH_W2  = 2'd2,
        PH_BG  = 2'd3
    } phase_e;

    localparam logic [9:0] DEF_PARK_X = 10'd1023;
    localparam logic [9:0] DEF_PARK_Y = 10'd511;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] data;
    } pixel_t;

    function automatic logic is_issue_phase(input phase_e ph);
        return (ph == PH_W1) || (ph == PH_W2);
    endfunction

endpackage

// File: rtl/sram_write_arbiter_if.sv
// Producer-side handshake plus the program_* bus towards the SRAM controller.
// The slave modport is the arbiter; master is the producer/controller side.
interface sram_write_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0][9:0]   req_x;
    logic [NUM_REQ-1:0][9:0]   req_y;
    logic [NUM_REQ-1:0][15:0]  req_data;
    logic [9:0]                program_x;
    logic [9:0]                program_y;
    logic [15:0]               program_data;

    modport master (
        output req_valid, req_x, req_y, req_data,
        input  req_ready, program_x, program_y, program_data
    );

    modport slave (
        input  req_valid, req_x, req_y, req_data,
        output req_ready, program_x, program_y, program_data
    );
endinterface

// File: rtl/sram_write_arbiter_rr.sv
// Combinational round-robin picker: first valid requester at or above ptr_i, with wrap.
// The pointer register lives in the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic               enable_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               found_o
);

    always_comb begin
        int  j;
        logic hit;
        j       = 0;
        hit     = 1'b0;
        grant_o = '0;
        idx_o   = '0;
        if (enable_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                j = (int'(ptr_i) + i) % NUM_REQ;
                if (!hit && valid_i[j]) begin
                    grant_o[j] = 1'b1;
                    idx_o      = IDX_W'(j);
                    hit        = 1'b1;
                end
            end
        end
        found_o = hit;
    end

endmodule

// File: rtl/sram_write_arbiter.sv
// Shares the controller's two write slots per 4-cycle round among pixel producers,
// parking the program_* bus off-screen when idle and across frame swaps.
module sram_write_arbiter
    import sram_arb_pkg::*;
#(
    parameter int          NUM_REQ     = 3,
    parameter logic [15:0] TRANSPARENT = 16'h0000,
    parameter logic [9:0]  PARK_X      = DEF_PARK_X,
    parameter logic [9:0]  PARK_Y      = DEF_PARK_Y
) (
    input  logic                sram_clk,
    input  logic                reset,
    input  logic                frame_clk_i,
    sram_write_arbiter_if.slave bus,
    output logic                frame_start_o,
    output logic [18:0]         write_count_o,
    output logic [7:0]          drop_count_o
);

    localparam int     IDX_W    = $clog2(NUM_REQ);
    localparam pixel_t PARK_PIX = '{x: PARK_X, y: PARK_Y, data: 16'h0000};

    phase_e             phase_q, phase_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    pixel_t             pix_q, pix_d;
    logic               staged_q, staged_d;
    logic [18:0]        wcount_q, wcount_d;
    logic [7:0]         dcount_q, dcount_d;
    logic               frame_prev_q, frame_edge_q, frame_edge_dly_q;

    logic               block_n;
    logic               issue;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_found;
    pixel_t             gnt_pix;

    always_ff @(posedge sram_clk or posedge reset) begin
        if (reset) begin
            phase_q          <= PH_W1;
            rr_ptr_q         <= '0;
            pix_q            <= PARK_PIX;
            staged_q         <= 1'b0;
            wcount_q         <= '0;
            dcount_q         <= '0;
            frame_prev_q     <= 1'b0;
            frame_edge_q     <= 1'b0;
            frame_edge_dly_q <= 1'b0;
        end else begin
            phase_q          <= phase_d;
            rr_ptr_q         <= rr_ptr_d;
            pix_q            <= pix_d;
            staged_q         <= staged_d;
            wcount_q         <= wcount_d;
            dcount_q         <= dcount_d;
            frame_prev_q     <= frame_clk_i;
            frame_edge_q     <= frame_clk_i & ~frame_prev_q;
            frame_edge_dly_q <= frame_edge_q;
        end
    end

    // Grants are suppressed in the frame-edge cycle and the one after it.
    always_comb begin
        phase_d = phase_e'(phase_q + 2'd1);
        block_n = ~(frame_edge_q | frame_edge_dly_q);
        issue   = is_issue_phase(phase_q) && block_n;
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .valid_i  (bus.req_valid),
        .ptr_i    (rr_ptr_q),
        .enable_i (issue),
        .grant_o  (grant),
        .idx_o    (gnt_idx),
        .found_o  (gnt_found)
    );

    // A pixel still held at a frame swap belongs to the old frame, so it is parked and counted as dropped.
    always_comb begin
        gnt_pix  = '{x: bus.req_x[gnt_idx], y: bus.req_y[gnt_idx], data: bus.req_data[gnt_idx]};
        pix_d    = pix_q;
        staged_d = staged_q;
        wcount_d = wcount_q;
        dcount_d = dcount_q;
        rr_ptr_d = rr_ptr_q;
        if (issue) begin
            pix_d    = PARK_PIX;
            staged_d = 1'b0;
            if (gnt_found) begin
                rr_ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                if (gnt_pix.data != TRANSPARENT) begin
                    pix_d    = gnt_pix;
                    staged_d = 1'b1;
                    if (wcount_q != '1) wcount_d = wcount_q + 1'b1;
                end
            end
        end
        if (frame_edge_q) begin
            pix_d    = PARK_PIX;
            staged_d = 1'b0;
            wcount_d = '0;
            if (staged_q && dcount_q != '1) dcount_d = dcount_q + 1'b1;
        end
    end

    assign bus.req_ready    = grant;
    assign bus.program_x    = pix_q.x;
    assign bus.program_y    = pix_q.y;
    assign bus.program_data = pix_q.data;
    assign frame_start_o    = frame_edge_q;
    assign write_count_o    = wcount_q;
    assign drop_count_o     = dcount_q;

endmodule

// File: tb/tb_sram_write_arbiter.sv
// Directed bench for sram_write_arbiter: a per-cycle vector table from reset,
// then hand-written sequences for transparency, idle parking, frame swap and mid-stream reset.
module tb_sram_write_arbiter;

    localparam logic [9:0]  PX = 10'd1023;
    localparam logic [9:0]  PY = 10'd511;

    typedef struct {
        logic [2:0]  valid;
        logic [2:0]  ready;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] d;
        logic [18:0] wc;
    } vec_t;

    logic        sram_clk;
    logic        reset;
    logic        frame_clk;
    logic        frame_start;
    logic [18:0] write_count;
    logic [7:0]  drop_count;

    int tests;
    int failed;
    int accepts;

    logic [9:0]  reqX [3];
    logic [9:0]  reqY [3];
    logic [15:0] reqD [3];
    vec_t        vecs [14];

    sram_write_arbiter_if #(.NUM_REQ(3)) bus ();

    sram_write_arbiter #(.NUM_REQ(3)) dut (
        .sram_clk      (sram_clk),
        .reset         (reset),
        .frame_clk_i   (frame_clk),
        .bus           (bus),
        .frame_start_o (frame_start),
        .write_count_o (write_count),
        .drop_count_o  (drop_count)
    );

    initial begin
        sram_clk = 1'b0;
        forever #5 sram_clk = ~sram_clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge sram_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] v, input logic f);
        bus.req_valid = v;
        frame_clk     = f;
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] rdy, input logic [9:0] x,
                               input logic [9:0] y, input logic [15:0] d, input logic [18:0] wc,
                               input logic [7:0] dc, input logic fs);
        @(negedge sram_clk);
        check({tag, ".ready"}, 32'(bus.req_ready), 32'(rdy));
        check({tag, ".x"},     32'(bus.program_x), 32'(x));
        check({tag, ".y"},     32'(bus.program_y), 32'(y));
        check({tag, ".data"},  32'(bus.program_data), 32'(d));
        check({tag, ".wcnt"},  32'(write_count), 32'(wc));
        check({tag, ".dcnt"},  32'(drop_count), 32'(dc));
        check({tag, ".fstart"}, 32'(frame_start), 32'(fs));
    endtask

    // src < 0 means the outputs are expected parked.
    function automatic vec_t mk(input logic [2:0] v, input logic [2:0] r, input int src, input int wc);
        vec_t t;
        t.valid = v;
        t.ready = r;
        t.x     = (src < 0) ? PX : reqX[src];
        t.y     = (src < 0) ? PY : reqY[src];
        t.d     = (src < 0) ? 16'h0000 : reqD[src];
        t.wc    = 19'(wc);
        return t;
    endfunction

    initial begin
        int g;
        tests   = 0;
        failed  = 0;
        accepts = 0;
        reqX = '{10'd5, 10'd11, 10'd12};
        reqY = '{10'd7, 10'd21, 10'd22};
        reqD = '{16'hF800, 16'h1001, 16'h1002};

        // Cycle 0 is phase 0 with rr_ptr 0; expected outputs are the registered values seen in that cycle.
        vecs[0]  = mk(3'b001, 3'b001, -1, 0);
        vecs[1]  = mk(3'b001, 3'b000,  0, 1);
        vecs[2]  = mk(3'b111, 3'b010,  0, 1);
        vecs[3]  = mk(3'b111, 3'b000,  1, 2);
        vecs[4]  = mk(3'b111, 3'b100,  1, 2);
        vecs[5]  = mk(3'b111, 3'b000,  2, 3);
        vecs[6]  = mk(3'b000, 3'b000,  2, 3);
        vecs[7]  = mk(3'b010, 3'b000, -1, 3);
        vecs[8]  = mk(3'b110, 3'b010, -1, 3);
        vecs[9]  = mk(3'b000, 3'b000,  1, 4);
        vecs[10] = mk(3'b101, 3'b100,  1, 4);
        vecs[11] = mk(3'b101, 3'b000,  2, 5);
        vecs[12] = mk(3'b101, 3'b001,  2, 5);
        vecs[13] = mk(3'b000, 3'b000,  0, 6);

        reset         = 1'b1;
        frame_clk     = 1'b0;
        bus.req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            bus.req_x[i]    = reqX[i];
            bus.req_y[i]    = reqY[i];
            bus.req_data[i] = reqD[i];
        end

        repeat (2) @(posedge sram_clk);
        #1;
        check("reset.x",      32'(bus.program_x), 32'(PX));
        check("reset.y",      32'(bus.program_y), 32'(PY));
        check("reset.data",   32'(bus.program_data), 32'h0);
        check("reset.wcnt",   32'(write_count), 32'h0);
        check("reset.dcnt",   32'(drop_count), 32'h0);
        check("reset.fstart", 32'(frame_start), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].valid, 1'b0);
            checkOutput($sformatf("vec%0d", i), vecs[i].ready, vecs[i].x, vecs[i].y,
                        vecs[i].d, vecs[i].wc, 8'd0, 1'b0);
            nextCycle();
        end

        // Transparent pixel from req1 in a phase-2 cycle: accepted, but parks and is not counted.
        bus.req_data[1] = 16'h0000;
        applyStimulus(3'b010, 1'b0);
        checkOutput("transp_accept", 3'b010, reqX[0], reqY[0], reqD[0], 19'd6, 8'd0, 1'b0);
        nextCycle();
        applyStimulus(3'b000, 1'b0);
        checkOutput("transp_park", 3'b000, PX, PY, 16'h0, 19'd6, 8'd0, 1'b0);
        nextCycle();
        bus.req_data[1] = reqD[1];

        for (int k = 0; k < 8; k++) begin
            applyStimulus(3'b000, 1'b0);
            checkOutput($sformatf("idle%0d", k), 3'b000, PX, PY, 16'h0, 19'd6, 8'd0, 1'b0);
            nextCycle();
        end

        // Frame swap: pixel staged at the end of phase 2, frame_clk rises in phase 3, edge cycle is phase 0.
        applyStimulus(3'b000, 1'b0);
        checkOutput("fs_ph0", 3'b000, PX, PY, 16'h0, 19'd6, 8'd0, 1'b0);
        nextCycle();
        applyStimulus(3'b000, 1'b0);
        checkOutput("fs_ph1", 3'b000, PX, PY, 16'h0, 19'd6, 8'd0, 1'b0);
        nextCycle();
        applyStimulus(3'b001, 1'b0);
        checkOutput("fs_grant", 3'b001, PX, PY, 16'h0, 19'd6, 8'd0, 1'b0);
        nextCycle();
        applyStimulus(3'b000, 1'b1);
        checkOutput("fs_rise", 3'b000, reqX[0], reqY[0], reqD[0], 19'd7, 8'd0, 1'b0);
        nextCycle();
        applyStimulus(3'b111, 1'b1);
        checkOutput("fs_edge", 3'b000, reqX[0], reqY[0], reqD[0], 19'd7, 8'd0, 1'b1);
        nextCycle();
        applyStimulus(3'b111, 1'b1);
        checkOutput("fs_block", 3'b000, PX, PY, 16'h0, 19'd0, 8'd1, 1'b0);
        nextCycle();
        applyStimulus(3'b111, 1'b1);
        checkOutput("fs_resume", 3'b010, PX, PY, 16'h0, 19'd0, 8'd1, 1'b0);
        nextCycle();
        applyStimulus(3'b000, 1'b0);
        checkOutput("fs_after", 3'b000, reqX[1], reqY[1], reqD[1], 19'd1, 8'd1, 1'b0);
        nextCycle();

        // Stage a pixel, then assert reset part-way through the next phase-2 cycle.
        applyStimulus(3'b001, 1'b0);
        checkOutput("pre_rst0", 3'b001, reqX[1], reqY[1], reqD[1], 19'd1, 8'd1, 1'b0);
        nextCycle();
        applyStimulus(3'b000, 1'b0);
        checkOutput("pre_rst1", 3'b000, reqX[0], reqY[0], reqD[0], 19'd2, 8'd1, 1'b0);
        nextCycle();
        applyStimulus(3'b000, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst.x",     32'(bus.program_x), 32'(PX));
        check("mid_rst.y",     32'(bus.program_y), 32'(PY));
        check("mid_rst.data",  32'(bus.program_data), 32'h0);
        check("mid_rst.wcnt",  32'(write_count), 32'h0);
        check("mid_rst.dcnt",  32'(drop_count), 32'h0);
        check("mid_rst.ready", 32'(bus.req_ready), 32'h0);
        @(posedge sram_clk);
        #1;
        reset = 1'b0;

        // After reset release all three requesters stay valid: strict rotation 0,1,2 on even phases.
        for (int k = 0; k < 12; k++) begin
            logic [2:0] expRdy;
            expRdy = (k % 2 == 0) ? 3'(1 << ((k / 2) % 3)) : 3'b000;
            applyStimulus(3'b111, 1'b0);
            if (k == 0) begin
                checkOutput("rot0", expRdy, PX, PY, 16'h0, 19'd0, 8'd0, 1'b0);
            end else begin
                g = ((k - 1) / 2) % 3;
                checkOutput($sformatf("rot%0d", k), expRdy, reqX[g], reqY[g], reqD[g],
                            19'((k + 1) / 2), 8'd0, 1'b0);
            end
            check($sformatf("rot%0d.onehot", k), 32'($countones(bus.req_ready) <= 1), 32'd1);
            accepts += $countones(bus.req_ready);
            nextCycle();
        end
        check("rot.accepts", 32'(accepts), 32'd6);
        applyStimulus(3'b000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
